spi_master: RTL

SPI mode-0 initiator that issues fixed 32-bit frames: opcode byte, address byte, two data bytes, MSB first. It is the host-side counterpart of the `spi` slave. It turns a single-beat command handshake into `csn`/`sclk`/`mosi` activity and returns the 16 bits shifted in on `miso` during the data bytes. It sits in fabric between a register or AXI front end and the off-block SPI pins, and also serves as the reusable stimulus engine for slave benches.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_master_if.sv | 22 ++
 rtl/spi_master_sclk_gen.sv | 74 +++++++
 rtl/spi_master.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants, opcodes, FSM state type and parameter-legality check
// for the SPI initiator/target pair.
package spi_pkg;

   localparam int FRAME_BITS = 32;

   localparam logic [7:0] SPI_OP_RD = 8'h41;
   localparam logic [7:0] SPI_OP_WR = 8'h42;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_LAG   = 3'd3,
      ST_GAP   = 3'd4
   } spi_mst_state_t;

   function automatic bit spi_mst_params_ok(input int clk_div, input int cs_lead,
                                            input int cs_lag, input int cs_idle);
      return (clk_div >= 2) && (cs_lead >= 1) && (cs_lag >= 1) && (cs_idle >= 1);
   endfunction

endpackage

// File: rtl/spi_master_if.sv
// Command/response handshake between a front end (master modport) and the
// spi_master block (slave modport).
interface spi_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        busy;

   modport master (
      output cmd_valid, cmd_opcode, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, busy
   );
endinterface

// File: rtl/spi_master_sclk_gen.sv
// Bit-cell timer: registered sclk plus fall/sample strobes and the
// end-of-frame flag. Each bit is 2*CLK_DIV cycles, sclk high first.
module spi_master_sclk_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int SAMPLE_CYC = CLK_DIV - 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic start_i,
   input  logic run_i,
   output logic sclk_o,
   output logic fall_o,
   output logic sample_o,
   output logic done_o
);
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CELL_LAST = CW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_CYC);
   localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

   logic [CW-1:0] cyc_d, cyc_q;
   logic [BW-1:0] bit_d, bit_q;
   logic          sclk_d, sclk_q;
   logic          end_cell_s, rise_s;

   assign end_cell_s = run_i && (cyc_q == CELL_LAST);
   assign fall_o     = run_i && (cyc_q == HALF_LAST);
   assign sample_o   = run_i && (cyc_q == SAMPLE_AT);
   assign done_o     = end_cell_s && (bit_q == LAST_BIT);
   assign rise_s     = start_i || (end_cell_s && !done_o);
   assign sclk_o     = sclk_q;

   // cycle-in-bit and bit counters; sclk rises at cell start, falls mid-cell
   always_comb begin
      cyc_d  = cyc_q;
      bit_d  = bit_q;
      sclk_d = sclk_q;
      if (start_i) begin
         cyc_d = '0;
         bit_d = '0;
      end else if (end_cell_s) begin
         cyc_d = '0;
         bit_d = bit_q + BW'(1);
      end else if (run_i) begin
         cyc_d = cyc_q + CW'(1);
      end else begin
         cyc_d = cyc_q;
      end
      if (rise_s) begin
         sclk_d = 1'b1;
      end else if (fall_o) begin
         sclk_d = 1'b0;
      end else begin
         sclk_d = sclk_q;
      end
   end

   // counter and sclk registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cyc_q  <= '0;
         bit_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cyc_q  <= cyc_d;
         bit_q  <= bit_d;
         sclk_q <= sclk_d;
      end
   end
endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator issuing 32-bit {opcode, addr, wdata} frames, MSB first.
// Build option SPI_MASTER_MISO_SYNC_EN: 2-flop miso synchronizer, later sample point.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int CS_LEAD = 5,
   parameter int CS_LAG  = 5,
   parameter int CS_IDLE = 4
) (
   input  logic         clk,
   input  logic         rstn,
   spi_master_if.slave  cmd,
   output logic         sclk_o,
   output logic         csn_o,
   output logic         mosi_o,
   input  logic         miso_i
);
   localparam logic [15:0] LEAD_LAST = 16'(CS_LEAD - 1);
   localparam logic [15:0] LAG_LAST  = 16'(CS_LAG - 1);
   localparam logic [15:0] IDLE_LAST = 16'(CS_IDLE - 1);

   if (!spi_mst_params_ok(CLK_DIV, CS_LEAD, CS_LAG, CS_IDLE)) begin : g_bad_params
      $error("spi_master: illegal timing parameters");
   end

   spi_mst_state_t state_d, state_q;
   logic [15:0] cnt_d, cnt_q;
   logic [FRAME_BITS-1:0] tx_d, tx_q;
   logic [15:0] rx_d, rx_q, rsp_rdata_d, rsp_rdata_q;
   logic csn_d, csn_q, mosi_d, mosi_q, cmd_ready_d, cmd_ready_q;
   logic busy_d, busy_q, rsp_valid_d, rsp_valid_q;
   logic accept_s, start_s, run_s, fall_s, sample_s, done_s, miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
   localparam int SAMPLE_CYC = CLK_DIV + 1;
   logic miso_meta_q, miso_sync_q;

   // two-flop synchronizer; its latency is absorbed by the later sample point
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
      end else begin
         miso_meta_q <= miso_i;
         miso_sync_q <= miso_meta_q;
      end
   end
   assign miso_s = miso_sync_q;
`else
   localparam int SAMPLE_CYC = CLK_DIV - 1;
   assign miso_s = miso_i;
`endif

   assign accept_s = cmd.cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
   assign start_s  = (state_q == ST_LEAD) && (cnt_q == LEAD_LAST);
   assign run_s    = (state_q == ST_SHIFT);

   spi_master_sclk_gen #(.CLK_DIV(CLK_DIV), .SAMPLE_CYC(SAMPLE_CYC)) u_sclk_gen (
      .clk      (clk),
      .rstn     (rstn),
      .start_i  (start_s),
      .run_i    (run_s),
      .sclk_o   (sclk_o),
      .fall_o   (fall_s),
      .sample_o (sample_s),
      .done_o   (done_s)
   );

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next-state: cnt counts cycles spent in the timed chip-select phases
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 16'd0;
            if (accept_s) state_d = ST_LEAD;
            else          state_d = ST_IDLE;
         end
         ST_LEAD: begin
            if (cnt_q == LEAD_LAST) begin
               state_d = ST_SHIFT;
               cnt_d   = 16'd0;
            end else begin
               state_d = ST_LEAD;
            end
         end
         ST_SHIFT: begin
            cnt_d = 16'd0;
            if (done_s) state_d = ST_LAG;
            else        state_d = ST_SHIFT;
         end
         ST_LAG: begin
            if (cnt_q == LAG_LAST) begin
               state_d = ST_GAP;
               cnt_d   = 16'd0;
            end else begin
               state_d = ST_LAG;
            end
         end
         ST_GAP: begin
            if (cnt_q == IDLE_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
            end else begin
               state_d = ST_GAP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // outputs follow state_d so every pin and flag is a plain flop
   always_comb begin
      csn_d       = !((state_d == ST_LEAD) || (state_d == ST_SHIFT) || (state_d == ST_LAG));
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = (state_q == ST_LAG) && (state_d == ST_GAP);
      if (accept_s) begin
         tx_d = {cmd.cmd_opcode, cmd.cmd_addr, cmd.cmd_wdata};
      end else if (fall_s) begin
         tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
      end else begin
         tx_d = tx_q;
      end
      mosi_d = tx_d[FRAME_BITS-1];
      if (sample_s) rx_d = {rx_q[14:0], miso_s};
      else          rx_d = rx_q;
      if (rsp_valid_d) rsp_rdata_d = rx_q;
      else             rsp_rdata_d = rsp_rdata_q;
   end

   // output and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         csn_q       <= 1'b1;
         mosi_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         tx_q        <= '0;
         rx_q        <= 16'h0000;
      end else begin
         csn_q       <= csn_d;
         mosi_q      <= mosi_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
      end
   end

   assign csn_o         = csn_q;
   assign mosi_o        = mosi_q;
   assign cmd.cmd_ready = cmd_ready_q;
   assign cmd.busy      = busy_q;
   assign cmd.rsp_valid = rsp_valid_q;
   assign cmd.rsp_rdata = rsp_rdata_q;
endmodule
